// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the request sources and decoder_rr_arbiter.
// The master drives requests and the release pulse; the slave returns the decoder-format grant.
interface decoder_rr_arbiter_if;
    logic       iEna;
    logic [7:0] iReq;
    logic       iDone;
    logic [7:0] oGnt;
    logic [2:0] oIdx;
    logic       oBusy;
    logic       oTimeout;

    modport master (
        output iEna, iReq, iDone,
        input  oGnt, oIdx, oBusy, oTimeout
    );

    modport slave (
        input  iEna, iReq, iDone,
        output oGnt, oIdx, oBusy, oTimeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of the 3-8 decoder select lines: IDLE -> GRANT -> RELEASE with one dead cycle.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT).
module decoder_rr_arbiter #(
    parameter int TIMEOUT = 16
) (
    input logic                  iClk,
    input logic                  iRst_n,
    decoder_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } stateT;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : gTimeoutRange
        $error("decoder_rr_arbiter: TIMEOUT must be within 2..255");
    end

    stateT      state, stateNext;
    logic [7:0] gnt, gntNext;
    logic [2:0] idx, idxNext;
    logic [2:0] ptr, ptrNext;
    logic       busy, busyNext;
    logic       pickValid;
    logic [2:0] pickIdx;
    logic       wdExpire;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wdCount, wdCountNext;
    logic       timeoutPulse, timeoutNext;

    assign wdExpire = (wdCount == WD_LAST);
`else
    assign wdExpire = 1'b0;
`endif

    // Scan from ptr downward in offset so the smallest offset from ptr wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (bus.iReq[ptr + 3'(i)]) begin
                pickValid = 1'b1;
                pickIdx   = ptr + 3'(i);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= IDLE;
            gnt          <= 8'hFF;
            idx          <= 3'd0;
            ptr          <= 3'd0;
            busy         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdCount      <= 8'd0;
            timeoutPulse <= 1'b0;
`endif
        end else begin
            state        <= stateNext;
            gnt          <= gntNext;
            idx          <= idxNext;
            ptr          <= ptrNext;
            busy         <= busyNext;
`ifdef ARB_TIMEOUT_EN
            wdCount      <= wdCountNext;
            timeoutPulse <= timeoutNext;
`endif
        end
    end

    // Next-state and next-output logic; every output is the registered copy of these.
    always_comb begin
        stateNext   = state;
        gntNext     = gnt;
        idxNext     = idx;
        ptrNext     = ptr;
        busyNext    = busy;
`ifdef ARB_TIMEOUT_EN
        wdCountNext = wdCount;
        timeoutNext = 1'b0;
`endif
        case (state)
            IDLE: begin
                gntNext  = 8'hFF;
                busyNext = 1'b0;
                if (bus.iEna && pickValid) begin
                    stateNext   = GRANT;
                    idxNext     = pickIdx;
                    gntNext     = ~(8'b1 << pickIdx);
                    busyNext    = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    wdCountNext = 8'd0;
`endif
                end
            end
            GRANT: begin
                // A dropped request does not end the grant; only done, disable or the watchdog do.
                if (bus.iDone || !bus.iEna || wdExpire) begin
                    stateNext   = RELEASE;
                    gntNext     = 8'hFF;
                    busyNext    = 1'b0;
                    ptrNext     = idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    timeoutNext = wdExpire && !bus.iDone && bus.iEna;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    wdCountNext = wdCount + 8'd1;
`endif
                end
            end
            RELEASE: begin
                stateNext = IDLE;
                gntNext   = 8'hFF;
                busyNext  = 1'b0;
            end
            default: begin
                stateNext = IDLE;
                gntNext   = 8'hFF;
                busyNext  = 1'b0;
            end
        endcase
    end

    assign bus.oGnt  = gnt;
    assign bus.oIdx  = idx;
    assign bus.oBusy = busy;
`ifdef ARB_TIMEOUT_EN
    assign bus.oTimeout = timeoutPulse;
`else
    assign bus.oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: expected grants are queued as requests are driven
// and popped when the arbiter shows a new owner.
module tb_decoder_rr_arbiter;

    logic iClk = 1'b0;
    logic iRst_n;
    int   checkCount = 0;
    int   errorCount = 0;
    logic [10:0] expQueue[$];

    decoder_rr_arbiter_if arbBus ();

    decoder_rr_arbiter #(.TIMEOUT(4)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (arbBus)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic applyStimulus(input logic ena, input logic [7:0] req, input logic done);
        arbBus.iEna  = ena;
        arbBus.iReq  = req;
        arbBus.iDone = done;
    endtask

    task automatic pushGrant(input logic [2:0] n);
        logic [7:0] g;
        g = ~(8'b1 << n);
        expQueue.push_back({g, n});
    endtask

    task automatic checkGrant(input string tag);
        logic [10:0] e;
        if (expQueue.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 32'(expQueue.size()), 32'd1);
        end else begin
            e = expQueue.pop_front();
            checkOutput({tag, "_gnt"},  32'(arbBus.oGnt),  32'(e[10:3]));
            checkOutput({tag, "_idx"},  32'(arbBus.oIdx),  32'(e[2:0]));
            checkOutput({tag, "_busy"}, 32'(arbBus.oBusy), 32'd1);
        end
    endtask

    // Pulse done for one edge, then expect the release cycle and the dead cycle both idle.
    task automatic releaseGrant(input string tag);
        arbBus.iDone = 1'b1;
        step();
        arbBus.iDone = 1'b0;
        checkOutput({tag, "_relGnt"},  32'(arbBus.oGnt),     32'hFF);
        checkOutput({tag, "_relBusy"}, 32'(arbBus.oBusy),    32'd0);
        checkOutput({tag, "_relTo"},   32'(arbBus.oTimeout), 32'd0);
        step();
        checkOutput({tag, "_deadGnt"}, 32'(arbBus.oGnt),     32'hFF);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        applyStimulus(1'b0, 8'h00, 1'b0);
        iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        checkOutput("rstGnt",  32'(arbBus.oGnt),     32'hFF);
        checkOutput("rstIdx",  32'(arbBus.oIdx),     32'd0);
        checkOutput("rstBusy", 32'(arbBus.oBusy),    32'd0);
        checkOutput("rstTo",   32'(arbBus.oTimeout), 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        step();
        checkOutput("idleGnt", 32'(arbBus.oGnt), 32'hFF);

        // Single requester, held grant and two-cycle re-grant gap
        applyStimulus(1'b1, 8'h04, 1'b0);
        pushGrant(3'd2);
        step();
        checkGrant("single");
        applyStimulus(1'b1, 8'h00, 1'b0);
        step();
        step();
        checkOutput("holdNoReq", 32'(arbBus.oGnt), 32'hFB);
        applyStimulus(1'b1, 8'h04, 1'b0);
        releaseGrant("single");
        checkOutput("keepIdx", 32'(arbBus.oIdx), 32'd2);
        pushGrant(3'd2);
        step();
        checkGrant("regrant");
        releaseGrant("regrant");

        // Asynchronous reset between edges
        applyStimulus(1'b1, 8'h10, 1'b0);
        pushGrant(3'd4);
        step();
        checkGrant("preReset");
        #2;
        iRst_n = 1'b0;
        #1;
        checkOutput("asyncGnt",  32'(arbBus.oGnt),  32'hFF);
        checkOutput("asyncBusy", 32'(arbBus.oBusy), 32'd0);
        checkOutput("asyncIdx",  32'(arbBus.oIdx),  32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b0);
        pushGrant(3'd0);
        step();
        checkGrant("afterReset");

        // Fairness with every requester active
        for (int i = 1; i <= 8; i++) begin
            releaseGrant("fair");
            pushGrant(3'(i % 8));
            step();
            checkGrant($sformatf("fair%0d", i));
        end

        // Pointer wrap
        releaseGrant("wrapA");
        applyStimulus(1'b1, 8'h20, 1'b0);
        pushGrant(3'd5);
        step();
        checkGrant("grant5");
        releaseGrant("grant5");
        applyStimulus(1'b1, 8'h03, 1'b0);
        pushGrant(3'd0);
        step();
        checkGrant("wrap0");
        releaseGrant("wrap0");
        pushGrant(3'd1);
        step();
        checkGrant("wrap1");
        releaseGrant("wrap1");
        applyStimulus(1'b1, 8'h20, 1'b0);
        pushGrant(3'd5);
        step();
        checkGrant("grant5b");
        releaseGrant("grant5b");
        applyStimulus(1'b1, 8'h21, 1'b0);
        pushGrant(3'd0);
        step();
        checkGrant("zeroBefore5");

        // Enable abort and disabled idle
        applyStimulus(1'b0, 8'h21, 1'b0);
        step();
        checkOutput("abortGnt",  32'(arbBus.oGnt),     32'hFF);
        checkOutput("abortBusy", 32'(arbBus.oBusy),    32'd0);
        checkOutput("abortTo",   32'(arbBus.oTimeout), 32'd0);
        checkOutput("abortIdx",  32'(arbBus.oIdx),     32'd0);
        step();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput($sformatf("enaOff%0d", i), 32'(arbBus.oGnt), 32'hFF);
        end
        applyStimulus(1'b1, 8'hFF, 1'b0);
        pushGrant(3'd1);
        step();
        checkGrant("afterAbort");

        // Done and disable together advance the pointer once
        applyStimulus(1'b0, 8'hFF, 1'b1);
        step();
        applyStimulus(1'b0, 8'hFF, 1'b0);
        checkOutput("bothGnt", 32'(arbBus.oGnt),     32'hFF);
        checkOutput("bothTo",  32'(arbBus.oTimeout), 32'd0);
        step();
        step();
        checkOutput("bothIdle", 32'(arbBus.oGnt), 32'hFF);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        pushGrant(3'd2);
        step();
        checkGrant("onceAdvance");

        // Watchdog behaviour on the grant to requester 2
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("wdHold%0d", k), 32'(arbBus.oGnt), 32'hFB);
        end
        step();
        checkOutput("wdRelGnt", 32'(arbBus.oGnt),     32'hFF);
        checkOutput("wdPulse",  32'(arbBus.oTimeout), 32'd1);
        step();
        checkOutput("wdPulseEnd", 32'(arbBus.oTimeout), 32'd0);
        checkOutput("wdDeadGnt",  32'(arbBus.oGnt),     32'hFF);
        pushGrant(3'd3);
        step();
        checkGrant("wdNext");
        releaseGrant("wdNext");
`else
        begin
            int heldCycles;
            int seenTimeout;
            heldCycles  = 0;
            seenTimeout = 0;
            for (int k = 0; k < 120; k++) begin
                step();
                if (arbBus.oGnt == 8'hFB) heldCycles++;
                if (arbBus.oTimeout) seenTimeout++;
            end
            checkOutput("longHold",  32'(heldCycles),  32'd120);
            checkOutput("noTimeout", 32'(seenTimeout), 32'd0);
            releaseGrant("longHold");
        end
`endif

        checkOutput("sbDrained", 32'(expQueue.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares the 3-8 decoder's output lines among eight requesters. It picks one requester at a time and holds the grant until that requester signals completion. The grant is driven as an active-low one-hot vector plus the encoded index, so it matches the decoder's output format. The block sits between the request sources and the decoded select lines, and it sequences grant, hold and release with a dead cycle between owners.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum grant length in cycles when the watchdog is compiled in. Legal range 2..255; the counter is 8 bits.

Ports:
- `iClk`  in  1  clock; all state updates on the rising edge.
- `iRst_n`  in  1  reset, asynchronous, active-low.
- `iEna`  in  1  arbiter enable. When 0, no new grants are issued and any current grant is aborted.
- `iReq`  in  8  request lines, active-high, bit n = requester n. Level-sensitive.
- `iDone`  in  1  single-cycle pulse from the current owner that releases the grant.
- `oGnt`  out  8  grant vector, active-low one-hot; 8'hFF = no grant.
- `oIdx`  out  3  index of the current or last grantee.
- `oBusy`  out  1  1 while in GRANT.
- `oTimeout`  out  1  one-cycle pulse on a watchdog release.

## Operation
- FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
- Reset values: state = IDLE, `oGnt` = 8'hFF, `oIdx` = 0, `oBusy` = 0, `oTimeout` = 0, rotation pointer `ptr` = 0, watchdog count = 0.
- **IDLE:**
  - If `iEna` = 1 and `iReq` ≠ 0, select the first set bit scanning `ptr`, `ptr`+1, …, `ptr`+7 (mod 8).
  - Load `oIdx` with the selected index n, set `oGnt` = ~(8'b1 << n) and `oBusy` = 1, then go to GRANT.
  - Otherwise stay in IDLE with `oGnt` = 8'hFF.
- **GRANT:**
  - The grant is held regardless of `iReq`; a requester dropping its request does not release it.
  - Exit to RELEASE on any of: `iDone` = 1, `iEna` = 0, or watchdog expiry.
  - On exit: `oGnt` = 8'hFF, `oBusy` = 0, `ptr` = `oIdx` + 1 with 3-bit wrap (7 → 0).
  - `oIdx` keeps its value after exit.
- **RELEASE:** one dead cycle with `oGnt` = 8'hFF, then unconditionally to IDLE.
- `iDone` is ignored in IDLE and RELEASE.
- Simultaneous `iDone` and `iEna` = 0 produce a single release. `ptr` advances exactly once.
- Reset asserted mid-grant: all outputs return to their reset values immediately, without waiting for a clock edge. `ptr` also resets to 0.

## Timing
- Request-to-grant latency: `iReq` sampled in IDLE at edge k; `oGnt`/`oIdx` valid after edge k.
- Release latency: `iDone` sampled at edge t; `oGnt` = 8'hFF after edge t. State is IDLE after t+1, and the next grant is visible after t+2 at the earliest.
- The minimum gap between two owners is therefore 2 cycles with `oGnt` = 8'hFF.
- A grant with no `iDone` lasts indefinitely, unless the watchdog is compiled in.

## Configuration
Macro `ARB_TIMEOUT_EN`.

**Defined:**
- An 8-bit counter clears on entry to GRANT and increments on each GRANT cycle.
- When the count equals `TIMEOUT`−1 and `iDone` = 0, the next edge moves to RELEASE and pulses `oTimeout` = 1 for exactly that one RELEASE cycle. The grant therefore lasts exactly `TIMEOUT` cycles.
- If `iDone` = 1 in that same cycle, it is a normal release and `oTimeout` stays 0.
- An `iEna` = 0 abort never pulses `oTimeout`.

**Undefined:**
- No counter is implemented.
- `oTimeout` is tied to 0.
- Grants end only on `iDone` or `iEna` = 0.

## Test plan
- **Async reset:** assert `iRst_n` = 0 between edges during a grant → `oGnt` = 8'hFF and `oBusy` = 0 before the next edge. After release, `iReq` = 8'hFF → first grant is index 0.
- **Single request:** `iReq` = 8'h04, `iEna` = 1 → one cycle later `oGnt` = 8'hFB, `oIdx` = 2, `oBusy` = 1. `iDone` pulse → 8'hFF next cycle, and the new grant appears 2 cycles after `iDone`.
- **Fairness:** `iReq` = 8'hFF held, `iDone` pulsed once per grant → `oIdx` sequence 0,1,2,…,7,0, with `oGnt` values FE, FD, FB, …, 7F, FE.
- **Wrap:** after granting 5 (`ptr` = 6), `iReq` = 8'h03 → grant 0 (`oGnt` = 8'hFE), then after `iDone` grant 1. `iReq` = 8'h21 with `ptr` = 6 → grant 0 before 5.
- **Enable:** `iEna` = 0 during a grant → `oGnt` = 8'hFF next cycle and `oTimeout` = 0. `iEna` = 0 with `iReq` = 8'hFF in IDLE → no grant for 10 cycles.
- **Watchdog:** with `ARB_TIMEOUT_EN`, `TIMEOUT` = 4 and no `iDone` → `oGnt` stays low for exactly 4 cycles, then 8'hFF with a one-cycle `oTimeout` pulse. Without the macro → grant held for 100+ cycles and `oTimeout` stays 0.
